// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default timing for the 8N1 UART
package uart_pkg;

  // 12 MHz clock / 115200 baud = 104 clocks per bit
  localparam int unsigned DEFAULT_BAUD_DIV = 103;
  localparam int unsigned DEFAULT_HALF_BIT = 51;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - bit-period counter, pulses tick_o at terminal count
// Ports: clk/rst, en_i (count enable), clr_i (sync clear to 0),
//        term_i (terminal count), tick_o (high on the terminal-count cycle).
module uart_baud_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == term_i);

  // Wraps to 0 on the tick so back-to-back bit periods need no extra clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART, independent TX and RX halves
// Ports: clk/rst; tx_byte/tx_start in, txd/tx_busy out (transmitter);
//        rxd in, rx_byte/rx_valid/rx_error/rx_active out (receiver).
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned HALF_BIT = DEFAULT_HALF_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       txd,
  output logic       tx_busy,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_active
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_TERM = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF_TERM = CW'(HALF_BIT);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       txd_q, txd_d;
  logic       tx_tick;

  uart_baud_timer #(.W(CW)) u_tx_timer (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tx_state_q != TX_IDLE),
    .clr_i  (tx_state_q == TX_IDLE),
    .term_i (BAUD_TERM),
    .tick_o (tx_tick)
  );

  // txd is registered and computed from the next state so the pin never glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_start) begin
          tx_shift_d = tx_byte;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          txd_d      = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_tick) begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (tx_state_q != TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_error_q, rx_error_d;
  logic       rx_s1_q, rx_s2_q;
  logic       rx_timing, rx_tick;

  assign rx_timing = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                     (rx_state_q == RX_STOP);

  // The start bit uses a half-period so every later sample lands mid-bit.
  uart_baud_timer #(.W(CW)) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .en_i   (rx_timing),
    .clr_i  (!rx_timing),
    .term_i ((rx_state_q == RX_START) ? HALF_TERM : BAUD_TERM),
    .tick_o (rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) rx_state_d = RX_START;
      RX_START: if (rx_tick) begin
        if (!rx_s2_q) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
        end else begin
          rx_state_d = RX_IDLE;  // glitch shorter than half a bit
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        else                      rx_bit_d   = rx_bit_q + 1'b1;
      end
      RX_STOP: if (rx_tick) begin
        if (rx_s2_q) begin
          rx_byte_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_error_d = 1'b1;
          rx_state_d = RX_WAIT_IDLE;
        end
      end
      // A break (line held low) must not be taken as a new start bit.
      RX_WAIT_IDLE: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign rx_error  = rx_error_q;
  assign rx_active = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver
module tb_uart_transceiver;

  localparam int unsigned BD    = 15;
  localparam int unsigned HB    = 7;
  localparam int unsigned BITC  = BD + 1;
  localparam int unsigned FRAME = 10 * BITC;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       txd;
  logic       tx_busy;
  logic       rxd;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_active;
  logic       loop_en;
  logic       bang;

  assign rxd = loop_en ? txd : bang;

  uart_transceiver #(.BAUD_DIV(BD), .HALF_BIT(HB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .rxd       (rxd),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .rx_active (rx_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int vcount = 0;
  int ecount = 0;
  int both   = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcount <= vcount + 1;
    if (rx_error === 1'b1) ecount <= ecount + 1;
    if (rx_valid === 1'b1 && rx_error === 1'b1) both <= both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit inj, input logic [7:0] ib,
                           output int busy_len);
    @(negedge clk);
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    busy_len = 0;
    while (tx_busy === 1'b1 && busy_len < int'(FRAME) + 100) begin
      busy_len++;
      if (inj && busy_len == int'(3 * BITC)) begin
        tx_byte  = ib;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
  endtask

  task automatic wait_rx_idle();
    int n = 0;
    while (rx_active !== 1'b0 && n < int'(4 * BITC)) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic loop_check(input string tag, input logic [7:0] b);
    int vb, eb, len;
    vb = vcount;
    eb = ecount;
    run_frame(b, 1'b0, 8'h00, len);
    wait_rx_idle();
    check({tag, "_busy_len"}, len, FRAME);
    check({tag, "_valid_cnt"}, vcount - vb, 1);
    check({tag, "_error_cnt"}, ecount - eb, 0);
    check({tag, "_rx_byte"}, {24'h0, rx_byte}, {24'h0, b});
  endtask

  task automatic bang_frame(input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      bang = bits[i];
      repeat (BITC) @(negedge clk);
    end
  endtask

  initial begin
    int vb, eb, len, mism, n;
    logic [7:0] held;

    rst      = 1'b1;
    loop_en  = 1'b1;
    bang     = 1'b1;
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd",       txd,       1);
    check("rst_tx_busy",   tx_busy,   0);
    check("rst_rx_byte",   rx_byte,   0);
    check("rst_rx_valid",  rx_valid,  0);
    check("rst_rx_error",  rx_error,  0);
    check("rst_rx_active", rx_active, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    loop_check("lb00", 8'h00);
    repeat (20) @(negedge clk);
    loop_check("lb55", 8'h55);
    repeat (20) @(negedge clk);
    loop_check("lbFF", 8'hFF);
    loop_check("lbA5", 8'hA5);
    loop_check("lb3C", 8'h3C);

    // full sweep of byte values
    mism = 0;
    vb   = vcount;
    eb   = ecount;
    for (int i = 0; i < 256; i++) begin
      run_frame(i[7:0], 1'b0, 8'h00, len);
      wait_rx_idle();
      if (rx_byte !== i[7:0] || len != int'(FRAME)) mism++;
    end
    check("sweep_mismatches", mism, 0);
    check("sweep_valid_cnt", vcount - vb, 256);
    check("sweep_error_cnt", ecount - eb, 0);

    // framing error: 0x42 with stop bit 0
    held    = rx_byte;
    loop_en = 1'b0;
    bang    = 1'b1;
    repeat (4) @(negedge clk);
    vb = vcount;
    eb = ecount;
    bang_frame({1'b0, 8'h42, 1'b0});
    bang = 1'b1;
    n = 0;
    while (ecount == eb && n < 2000) begin
      @(negedge clk);
      n++;
    end
    wait_rx_idle();
    check("ferr_error_cnt", ecount - eb, 1);
    check("ferr_valid_cnt", vcount - vb, 0);
    check("ferr_rx_byte", rx_byte, {24'h0, held});
    check("ferr_rx_active", rx_active, 0);
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    loop_check("after_ferr_AB", 8'hAB);

    // short low glitch
    loop_en = 1'b0;
    bang    = 1'b1;
    repeat (4) @(negedge clk);
    vb   = vcount;
    eb   = ecount;
    bang = 1'b0;
    repeat (HB - 3) @(negedge clk);
    check("glitch_active_during", rx_active, 1);
    bang = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    check("glitch_valid_cnt", vcount - vb, 0);
    check("glitch_error_cnt", ecount - eb, 0);
    check("glitch_active_after", rx_active, 0);
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    loop_check("after_glitch_96", 8'h96);

    // tx_start while busy is ignored
    vb = vcount;
    run_frame(8'h5A, 1'b1, 8'hC3, len);
    wait_rx_idle();
    check("busy_start_len", len, FRAME);
    check("busy_start_rx_byte", rx_byte, 8'h5A);
    check("busy_start_valid_cnt", vcount - vb, 1);
    repeat (2 * FRAME) @(negedge clk);
    check("busy_start_no_second_tx", tx_busy, 0);
    check("busy_start_no_second_rx", vcount - vb, 1);

    check("valid_error_overlap", both, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
